rv32i_exec_unit: RTL and testbench



---
 rtl/rv32i_exec_unit.sv | 100 ++++++++++
 tb/tb_rv32i_exec_unit.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_exec_unit.sv
// RV32I execute-stage slice: immediate decode, integer ALU and branch condition,
// plus a registered copy of result/take_b for the execute/memory boundary.
module rv32i_exec_unit (
   input  logic        clk,
   input  logic        resetn,
   input  logic [31:0] inst,
   input  logic [31:0] in_a,
   input  logic [31:0] in_b,
   output logic [31:0] imm,
   output logic [31:0] result,
   output logic        take_b,
   output logic [31:0] result_q,
   output logic        take_b_q
);

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic       alt;
   logic [4:0] shamt;
   logic       lt_signed;
   logic       lt_unsigned;

   assign opcode      = inst[6:0];
   assign funct3      = inst[14:12];
   assign alt         = inst[30];
   assign shamt       = in_b[4:0];
   assign lt_signed   = $signed(in_a) < $signed(in_b);
   assign lt_unsigned = in_a < in_b;

   always_comb begin
      imm = 32'd0;
      case (opcode)
         OPC_OP_IMM, OPC_LOAD, OPC_JALR:
            imm = {{20{inst[31]}}, inst[31:20]};
         OPC_STORE:
            imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
         OPC_BRANCH:
            imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
         OPC_LUI, OPC_AUIPC:
            imm = {inst[31:12], 12'd0};
         OPC_JAL:
            imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
         default:
            imm = 32'd0;
      endcase
   end

   // Only register-register ops honour the alt bit for subtract; OP-IMM's bit 30 is immediate data.
   always_comb begin
      result = in_a + in_b;
      if (opcode == OPC_OP || opcode == OPC_OP_IMM) begin
         case (funct3)
            3'b000:  result = (opcode == OPC_OP && alt) ? in_a - in_b : in_a + in_b;
            3'b001:  result = in_a << shamt;
            3'b010:  result = {31'd0, lt_signed};
            3'b011:  result = {31'd0, lt_unsigned};
            3'b100:  result = in_a ^ in_b;
            3'b101:  result = alt ? 32'($signed(in_a) >>> shamt) : in_a >> shamt;
            3'b110:  result = in_a | in_b;
            default: result = in_a & in_b;
         endcase
      end
   end

   always_comb begin
      take_b = 1'b0;
      if (opcode == OPC_BRANCH) begin
         case (funct3)
            3'b000:  take_b = in_a == in_b;
            3'b001:  take_b = in_a != in_b;
            3'b100:  take_b = lt_signed;
            3'b101:  take_b = !lt_signed;
            3'b110:  take_b = lt_unsigned;
            3'b111:  take_b = !lt_unsigned;
            default: take_b = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         result_q <= 32'd0;
         take_b_q <= 1'b0;
      end else begin
         result_q <= result;
         take_b_q <= take_b;
      end
   end

endmodule

// File: tb/tb_rv32i_exec_unit.sv
// Directed and randomized checks of rv32i_exec_unit against a behavioural reference model.
module tb_rv32i_exec_unit;

   logic        clk;
   logic        resetn;
   logic [31:0] inst;
   logic [31:0] in_a;
   logic [31:0] in_b;
   logic [31:0] imm;
   logic [31:0] result;
   logic        take_b;
   logic [31:0] result_q;
   logic        take_b_q;

   int checks   = 0;
   int failures = 0;

   rv32i_exec_unit dut (
      .clk      (clk),
      .resetn   (resetn),
      .inst     (inst),
      .in_a     (in_a),
      .in_b     (in_b),
      .imm      (imm),
      .result   (result),
      .take_b   (take_b),
      .result_q (result_q),
      .take_b_q (take_b_q)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: straight from the instruction-set rules.
   function automatic logic [31:0] m_imm(input logic [31:0] i);
      logic [31:0] r;
      r = 32'd0;
      case (i[6:0])
         7'b0010011, 7'b0000011, 7'b1100111: r = {{20{i[31]}}, i[31:20]};
         7'b0100011: r = {{20{i[31]}}, i[31:25], i[11:7]};
         7'b1100011: r = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
         7'b0110111, 7'b0010111: r = {i[31:12], 12'd0};
         7'b1101111: r = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
         default: r = 32'd0;
      endcase
      return r;
   endfunction

   function automatic logic [31:0] m_result(input logic [31:0] i, input logic [31:0] a,
                                            input logic [31:0] b);
      int sa, sb;
      int unsigned sh;
      logic [31:0] r;
      sa = a;
      sb = b;
      sh = b % 32;
      r = a + b;
      if (i[6:0] == 7'b0110011 || i[6:0] == 7'b0010011) begin
         case (i[14:12])
            3'd0: r = (i[6:0] == 7'b0110011 && i[30]) ? a - b : a + b;
            3'd1: r = a << sh;
            3'd2: r = (sa < sb) ? 32'd1 : 32'd0;
            3'd3: r = (a < b) ? 32'd1 : 32'd0;
            3'd4: r = a ^ b;
            3'd5: begin
               r = a >> sh;
               if (i[30] && a[31]) r = r | ~(32'hFFFF_FFFF >> sh);
            end
            3'd6: r = a | b;
            default: r = a & b;
         endcase
      end
      return r;
   endfunction

   function automatic logic m_take(input logic [31:0] i, input logic [31:0] a,
                                   input logic [31:0] b);
      int sa, sb;
      sa = a;
      sb = b;
      if (i[6:0] != 7'b1100011) return 1'b0;
      case (i[14:12])
         3'd0: return a == b;
         3'd1: return a != b;
         3'd4: return sa < sb;
         3'd5: return sa >= sb;
         3'd6: return a < b;
         3'd7: return a >= b;
         default: return 1'b0;
      endcase
   endfunction

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic apply(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b);
      inst = i;
      in_a = a;
      in_b = b;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Directed combinational step: check result/take_b (and imm) against literal expectations.
   task automatic dir(input string tag, input logic [31:0] i, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] exp_res, input logic exp_tk);
      apply(i, a, b);
      chk32({tag, "_result"}, result, exp_res);
      chk1({tag, "_take_b"}, take_b, exp_tk);
      $display("step %s inst=%h a=%h b=%h imm=%h result=%h take_b=%b",
               tag, i, a, b, imm, result, take_b);
   endtask

   logic [6:0] opc_tab [12];
   logic [31:0] r_inst, r_a, r_b, exp_res;
   logic        exp_tk;

   initial begin
      opc_tab = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b1100111, 7'b0100011, 7'b1100011,
                  7'b0110111, 7'b0010111, 7'b1101111, 7'b1110011, 7'b1100011, 7'b0110011};
      resetn = 1'b0;
      apply(32'h0020C463, 32'hFFFF_FFFF, 32'd1);

      // Reset holds registers at zero even while a taken branch sits on the inputs.
      tick();
      tick();
      chk32("reset_result_q", result_q, 32'd0);
      chk1("reset_take_b_q", take_b_q, 1'b0);

      // Release reset with add 5+7 applied.
      resetn = 1'b1;
      apply(32'h002081B3, 32'd5, 32'd7);
      tick();
      chk32("release_result_q", result_q, 32'd12);
      chk1("release_take_b_q", take_b_q, 1'b0);
      apply(32'h002081B3, 32'd10, 32'd20);
      chk32("follow_before_edge", result_q, 32'd12);
      tick();
      chk32("follow_after_edge", result_q, 32'd30);

      dir("add", 32'h002081B3, 32'd5, 32'd7, 32'd12, 1'b0);
      chk32("rtype_imm", imm, 32'd0);
      dir("sub", 32'h402081B3, 32'd5, 32'd7, 32'hFFFF_FFFE, 1'b0);
      dir("sra", 32'h4020D1B3, 32'h8000_0000, 32'd4, 32'hF800_0000, 1'b0);
      apply(32'h4040D093, 32'h8000_0000, 32'd0);
      chk32("srai_imm", imm, 32'h0000_0404);
      dir("srai", 32'h4040D093, 32'h8000_0000, imm, 32'hF800_0000, 1'b0);
      dir("srl", 32'h0020D1B3, 32'h8000_0000, 32'd4, 32'h0800_0000, 1'b0);
      apply(32'hFFF00093, 32'd0, 32'd0);
      chk32("addi_neg_imm", imm, 32'hFFFF_FFFF);
      dir("addi_neg", 32'hFFF00093, 32'd0, imm, 32'hFFFF_FFFF, 1'b0);
      apply(32'h40000093, 32'd1, 32'd0);
      chk32("addi_400_imm", imm, 32'h0000_0400);
      dir("addi_no_sub", 32'h40000093, 32'd1, imm, 32'h0000_0401, 1'b0);
      dir("blt", 32'h0020C463, 32'hFFFF_FFFF, 32'd1, 32'h0000_0000, 1'b1);
      chk32("blt_imm", imm, 32'd8);
      dir("bltu", 32'h0020E463, 32'hFFFF_FFFF, 32'd1, 32'h0000_0000, 1'b0);
      dir("beq", 32'h00208463, 32'd33, 32'd33, 32'd66, 1'b1);
      dir("nonbranch_eq", 32'h00008033, 32'd33, 32'd33, 32'd66, 1'b0);
      apply(32'h008000EF, 32'd0, 32'd0);
      chk32("jal_imm", imm, 32'd8);
      apply(32'h123450B7, 32'd0, 32'd0);
      chk32("lui_imm", imm, 32'h1234_5000);
      apply(32'hFE20AE23, 32'd0, 32'd0);
      chk32("sw_imm", imm, 32'hFFFF_FFFC);
      apply(32'h00001097, 32'h100, 32'd0);
      chk32("auipc_imm", imm, 32'h0000_1000);
      dir("auipc", 32'h00001097, 32'h100, imm, 32'h0000_1100, 1'b0);

      // Randomized: combinational outputs plus one-edge-later registered copy, with occasional reset.
      for (int n = 0; n < 300; n++) begin
         r_inst = $urandom;
         r_inst[6:0] = opc_tab[$urandom_range(0, 11)];
         if ($urandom_range(0, 15) == 0) r_inst[6:0] = 7'($urandom);
         case ($urandom_range(0, 3))
            0: begin r_a = $urandom; r_b = r_a; end
            1: begin r_a = $urandom_range(0, 40); r_b = $urandom_range(0, 40); end
            default: begin r_a = $urandom; r_b = $urandom; end
         endcase
         if ($urandom_range(0, 3) == 0) r_b = m_imm(r_inst);
         resetn = ($urandom_range(0, 9) != 0);
         apply(r_inst, r_a, r_b);
         exp_res = m_result(r_inst, r_a, r_b);
         exp_tk  = m_take(r_inst, r_a, r_b);
         chk32("rand_imm", imm, m_imm(r_inst));
         chk32("rand_result", result, exp_res);
         chk1("rand_take_b", take_b, exp_tk);
         tick();
         chk32("rand_result_q", result_q, resetn ? exp_res : 32'd0);
         chk1("rand_take_b_q", take_b_q, resetn ? exp_tk : 1'b0);
         $display("rand %0d inst=%h a=%h b=%h rstn=%b result=%h take_b=%b result_q=%h",
                  n, r_inst, r_a, r_b, resetn, result, take_b, result_q);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
